// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the CONV5x5 memory responder.
package conv_pkg;
    localparam int CONV_DW          = 13;
    localparam int CONV_AW          = 12;
    localparam int CONV_IMG_DEPTH   = 4096;
    localparam int CONV_L0_DEPTH    = 4096;
    localparam int CONV_L1_DEPTH    = 1024;
    localparam int CONV_TIMEOUT_CYC = 10000000;
    localparam int CONV_RCW         = 31;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/conv_mem_bank.sv
// Word-wide memory bank: one synchronous write port, NRD asynchronous read ports.
// Read ports are packed side by side, port 0 in the least significant slice.
module conv_mem_bank #(
    parameter int DEPTH = 4096,
    parameter int DW    = 13,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            assign rdata[gi*DW +: DW] = mem[raddr[gi*AW +: AW]];
        end
    endgenerate
endmodule

// File: rtl/conv_mem_responder.sv
// Memory/handshake responder for CONV5x5: image loader, layer banks, run watchdog.
// A layer read issued in the same cycle as a write to that word sees the old data.
module conv_mem_responder
    import conv_pkg::*;
#(
    parameter int DW          = CONV_DW,
    parameter int AW          = CONV_AW,
    parameter int IMG_DEPTH   = CONV_IMG_DEPTH,
    parameter int L0_DEPTH    = CONV_L0_DEPTH,
    parameter int L1_DEPTH    = CONV_L1_DEPTH,
    parameter int TIMEOUT_CYC = CONV_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [DW-1:0]       ld_data,
    output logic                ld_ready,
    input  logic                clr,
    input  logic                busy,
    output logic                ready,
    input  logic [AW-1:0]       iaddr,
    output logic [DW-1:0]       idata,
    input  logic                cwr,
    input  logic [AW-1:0]       caddr_wr,
    input  logic [DW-1:0]       cdata_wr,
    input  logic                crd,
    input  logic [AW-1:0]       caddr_rd,
    output logic [DW-1:0]       cdata_rd,
    input  logic                csel,
    input  logic                rb_sel,
    input  logic [AW-1:0]       rb_addr,
    output logic [DW-1:0]       rb_data,
    output logic                done,
    output logic                timeout,
    output logic                wr0_seen,
    output logic                wr1_seen,
    output logic                oob_wr,
    output logic [CONV_RCW-1:0] run_cycles
);
    localparam int IMG_AW = $clog2(IMG_DEPTH);
    localparam int L0_AW  = $clog2(L0_DEPTH);
    localparam int L1_AW  = $clog2(L1_DEPTH);

    state_e               state_q, state_d;
    logic                 started_q, started_d;
    logic [IMG_AW-1:0]    ld_cnt_q, ld_cnt_d;
    logic [CONV_RCW-1:0]  run_cycles_q, run_cycles_d;
    logic                 timeout_q, timeout_d;
    logic                 wr0_q, wr0_d;
    logic                 wr1_q, wr1_d;
    logic                 oob_q, oob_d;
    logic [DW-1:0]        rd_hold_q, rd_hold_d;

    logic                 img_we, l0_we, l1_we, l1_wr_ok, l1_rd_ok, rb_ok, oob_hit;
    logic [DW-1:0]        img_rd, l0_rd, l0_rb, l1_rd, l1_rb, rd_mux;

    assign l1_wr_ok = caddr_wr < AW'(L1_DEPTH);
    assign l1_rd_ok = caddr_rd < AW'(L1_DEPTH);
    assign rb_ok    = rb_addr  < AW'(L1_DEPTH);
    assign l0_we    = cwr && !csel;
    assign l1_we    = cwr && csel && l1_wr_ok;
    assign oob_hit  = cwr && csel && !l1_wr_ok;

    conv_mem_bank #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(IMG_AW), .NRD(1)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (ld_cnt_q),
        .wdata (ld_data),
        .raddr (iaddr[IMG_AW-1:0]),
        .rdata (img_rd)
    );

    conv_mem_bank #(.DEPTH(L0_DEPTH), .DW(DW), .AW(L0_AW), .NRD(2)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr[L0_AW-1:0]),
        .wdata (cdata_wr),
        .raddr ({rb_addr[L0_AW-1:0], caddr_rd[L0_AW-1:0]}),
        .rdata ({l0_rb, l0_rd})
    );

    conv_mem_bank #(.DEPTH(L1_DEPTH), .DW(DW), .AW(L1_AW), .NRD(2)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr ({rb_addr[L1_AW-1:0], caddr_rd[L1_AW-1:0]}),
        .rdata ({l1_rb, l1_rd})
    );

    assign rd_mux = csel ? (l1_rd_ok ? l1_rd : '0) : l0_rd;

    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        ld_cnt_d     = ld_cnt_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        wr0_d        = wr0_q;
        wr1_d        = wr1_q;
        oob_d        = oob_q;
        img_we       = 1'b0;
        rd_hold_d    = crd ? rd_mux : rd_hold_q;

        case (state_q)
            LOAD: begin
                // Loading waits one cycle after reset release so ld_ready starts low.
                if (started_q && ld_valid) begin
                    img_we   = 1'b1;
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == IMG_AW'(IMG_DEPTH - 1)) begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                if (busy) begin
                    state_d      = RUN;
                    run_cycles_d = '0;
                end
            end
            RUN: begin
                if (!busy) begin
                    state_d = DONE;
                end else if (run_cycles_q == CONV_RCW'(TIMEOUT_CYC - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    run_cycles_d = run_cycles_q + 1'b1;
                end
            end
            DONE: begin
                if (clr) begin
                    state_d   = LOAD;
                    ld_cnt_d  = '0;
                    timeout_d = 1'b0;
                    wr0_d     = 1'b0;
                    wr1_d     = 1'b0;
                    oob_d     = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase

        if (l0_we)   wr0_d = 1'b1;
        if (l1_we)   wr1_d = 1'b1;
        if (oob_hit) oob_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= LOAD;
            started_q    <= 1'b0;
            ld_cnt_q     <= '0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
            wr0_q        <= 1'b0;
            wr1_q        <= 1'b0;
            oob_q        <= 1'b0;
            rd_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            ld_cnt_q     <= ld_cnt_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            wr0_q        <= wr0_d;
            wr1_q        <= wr1_d;
            oob_q        <= oob_d;
            rd_hold_q    <= rd_hold_d;
        end
    end

    assign ld_ready   = started_q && (state_q == LOAD);
    assign ready      = (state_q == ARM);
    assign done       = (state_q == DONE);
    assign idata      = (state_q == RUN) ? img_rd : '0;
    assign cdata_rd   = crd ? rd_mux : rd_hold_q;
    assign rb_data    = rb_sel ? (rb_ok ? l1_rb : '0) : l0_rb;
    assign timeout    = timeout_q;
    assign wr0_seen   = wr0_q;
    assign wr1_seen   = wr1_q;
    assign oob_wr     = oob_q;
    assign run_cycles = run_cycles_q;
endmodule
